// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by the interface, the counter and the arbiter itself.
package dmem_pkg;

  localparam int DEFAULT_AW         = 8;
  localparam int DEFAULT_W          = 8;
  localparam int DEFAULT_STARVE_MAX = 4;

  typedef enum logic [1:0] {H_IDLE, H_PEND, H_DONE} host_st_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle shared by the core load/store path, the host loader and data_mem.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if import dmem_pkg::*; #(
  parameter int AW = DEFAULT_AW,
  parameter int W  = DEFAULT_W
);
  logic          core_rd;
  logic          core_wr;
  logic [AW-1:0] core_addr;
  logic [W-1:0]  core_wdata;
  logic [W-1:0]  core_rdata;
  logic          core_stall;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata;
  logic          host_ack;
  logic [W-1:0]  host_rdata;
  logic          host_busy;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  logic [15:0]   stall_ct;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata, host_busy,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata,
    output stall_ct
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata, host_busy,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata,
    input  stall_ct
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for both the host starvation counter and the core stall counter.
module sat_counter import dmem_pkg::*; #(
  parameter int          WIDTH = 16,
  parameter int unsigned MAX   = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count_o
);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != MaxVal)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (priority, zero latency) and a
// host loader whose access is forced through after STARVE_MAX waiting cycles.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int AW         = DEFAULT_AW,
  parameter int W          = DEFAULT_W,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          halt,
  dmem_arbiter_if.slave bus
);
  host_st_t      state_q, state_d;
  logic          pendWe_q, pendWe_d;
  logic [AW-1:0] pendAddr_q, pendAddr_d;
  logic [W-1:0]  pendWdata_q, pendWdata_d;
  logic [W-1:0]  hostRdata_q, hostRdata_d;
  logic [3:0]    waitCt;
  logic          coreReq;
  logic          hostGrant;

  assign coreReq   = bus.core_rd | bus.core_wr;
  assign hostGrant = (state_q == H_PEND) &&
                     (halt || !coreReq || (waitCt == 4'(STARVE_MAX)));

  // Waiting cycles only accumulate while a captured access is held off.
  sat_counter #(.WIDTH(4), .MAX(STARVE_MAX)) uWaitCt (
    .clk    (CLK),
    .rst_n  (reset_n),
    .clear  ((state_q != H_PEND) || hostGrant),
    .inc    (1'b1),
    .count_o(waitCt)
  );

  sat_counter #(.WIDTH(16), .MAX(32'h0000_FFFF)) uStallCt (
    .clk    (CLK),
    .rst_n  (reset_n),
    .clear  (1'b0),
    .inc    (bus.core_stall),
    .count_o(bus.stall_ct)
  );

  always_comb begin
    state_d     = state_q;
    pendWe_d    = pendWe_q;
    pendAddr_d  = pendAddr_q;
    pendWdata_d = pendWdata_q;
    hostRdata_d = hostRdata_q;
    case (state_q)
      H_IDLE: begin
        if (bus.host_req) begin
          pendWe_d    = bus.host_we;
          pendAddr_d  = bus.host_addr;
          pendWdata_d = bus.host_wdata;
          state_d     = H_PEND;
        end
      end
      H_PEND: begin
        if (hostGrant) begin
          if (!pendWe_q) begin
            hostRdata_d = bus.mem_rdata;
          end
          state_d = H_DONE;
        end
      end
      H_DONE:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= H_IDLE;
      pendWe_q    <= 1'b0;
      pendAddr_q  <= '0;
      pendWdata_q <= '0;
      hostRdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pendWe_q    <= pendWe_d;
      pendAddr_q  <= pendAddr_d;
      pendWdata_q <= pendWdata_d;
      hostRdata_q <= hostRdata_d;
    end
  end

  // The granted host borrows the port; otherwise the core path passes straight through.
  always_comb begin
    bus.mem_addr  = bus.core_addr;
    bus.mem_rd    = bus.core_rd;
    bus.mem_wr    = bus.core_wr;
    bus.mem_wdata = bus.core_wdata;
    if (hostGrant) begin
      bus.mem_addr  = pendAddr_q;
      bus.mem_rd    = !pendWe_q;
      bus.mem_wr    = pendWe_q;
      bus.mem_wdata = pendWdata_q;
    end
  end

  assign bus.core_stall = hostGrant & coreReq;
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.host_ack   = (state_q == H_DONE);
  assign bus.host_busy  = (state_q != H_IDLE);
  assign bus.host_rdata = hostRdata_q;

endmodule
